// File: rtl/bike_mac_stream_if.sv
//==============================================================================
// Module      : bike_mac_stream_if
// Description : Operand and result handshake bundle for bike_mac_stream.
//               Operand side: s_valid/s_ready, s_a (25b), s_b (18b),
//               s_bias (48b), s_last.
//               Result side : m_valid/m_ready, m_result (48b),
//               m_terms (c_CW b), m_ovf, m_err.
//               modport slave  - the MAC engine view
//               modport master - the producer/consumer (environment) view
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface bike_mac_stream_if #(
    parameter int MAX_TERMS = 1024
);
    // Must equal the term-counter width used inside bike_mac_stream.
    localparam int c_CW = $clog2(MAX_TERMS + 1);

    logic            s_valid;
    logic            s_ready;
    logic [24:0]     s_a;
    logic [17:0]     s_b;
    logic [47:0]     s_bias;
    logic            s_last;

    logic            m_valid;
    logic            m_ready;
    logic [47:0]     m_result;
    logic [c_CW-1:0] m_terms;
    logic            m_ovf;
    logic            m_err;

    modport slave (
        input  s_valid, s_a, s_b, s_bias, s_last, m_ready,
        output s_ready, m_valid, m_result, m_terms, m_ovf, m_err
    );

    modport master (
        output s_valid, s_a, s_b, s_bias, s_last, m_ready,
        input  s_ready, m_valid, m_result, m_terms, m_ovf, m_err
    );
endinterface

`default_nettype wire

// File: rtl/bike_mac_stream.sv
//==============================================================================
// Module      : bike_mac_stream
// Description : Streaming multiply-accumulate engine. Accepts bursts of
//               unsigned (a, b) pairs and returns bias + sum(a*b) as one
//               48-bit result per burst, with term count, overflow and
//               forced-termination flags.
// Ports       : clk    - rising-edge clock
//               resetn - synchronous, active-low reset
//               bus    - bike_mac_stream_if.slave (operand + result streams)
// Build macro : BIKE_MAC_SATURATE_EN - when defined the accumulator clamps at
//               48'hFFFF_FFFF_FFFF instead of wrapping modulo 2^48.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module bike_mac_stream #(
    parameter int MAX_TERMS = 1024
) (
    input  logic                clk,
    input  logic                resetn,
    bike_mac_stream_if.slave    bus
);

    localparam int              c_CW  = $clog2(MAX_TERMS + 1);
    localparam logic [c_CW-1:0] c_MAX = c_CW'(MAX_TERMS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [47:0]     r_acc;
    logic [47:0]     w_acc_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            r_ovf;
    logic            w_ovf_nxt;
    logic            r_err;
    logic            w_err_nxt;

    // One 25x18 multiply feeding one 48-bit add; the only register behind it
    // is r_acc, which keeps the whole term path inside a single DSP slice.
    logic [42:0]     w_prod;
    logic [47:0]     w_addend;
    logic [48:0]     w_sum;
    logic            w_first;
    logic            w_ovf_prev;
    logic [47:0]     w_acc_calc;
    logic            w_ovf_calc;
    logic [c_CW-1:0] w_cnt_inc;
    logic            w_hit_max;

    assign w_first    = (r_state == ST_IDLE);
    assign w_prod     = {18'd0, bus.s_a} * {25'd0, bus.s_b};
    assign w_addend   = w_first ? bus.s_bias : r_acc;
    assign w_sum      = {1'b0, w_addend} + {6'd0, w_prod};
    // Flags belong to the current burst: the first term starts clean.
    assign w_ovf_prev = w_first ? 1'b0 : r_ovf;
    assign w_ovf_calc = w_ovf_prev | w_sum[48];
    assign w_cnt_inc  = r_cnt + {{(c_CW-1){1'b0}}, 1'b1};
    assign w_hit_max  = (w_cnt_inc == c_MAX);

`ifdef BIKE_MAC_SATURATE_EN
    // Once clamped the accumulator is frozen at all-ones for the rest of the
    // burst; later products are discarded.
    always_comb begin
        w_acc_calc = w_sum[47:0];
        if (w_ovf_prev) begin
            w_acc_calc = r_acc;
        end else if (w_sum[48]) begin
            w_acc_calc = 48'hFFFF_FFFF_FFFF;
        end
    end
`else
    assign w_acc_calc = w_sum[47:0];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_err_nxt   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (bus.s_valid) begin
                    w_acc_nxt   = w_acc_calc;
                    w_cnt_nxt   = {{(c_CW-1){1'b0}}, 1'b1};
                    w_ovf_nxt   = w_ovf_calc;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = bus.s_last ? ST_OUT : ST_ACC;
                end
            end
            ST_ACC: begin
                if (bus.s_valid) begin
                    w_acc_nxt   = w_acc_calc;
                    w_cnt_nxt   = w_cnt_inc;
                    w_ovf_nxt   = w_ovf_calc;
                    w_err_nxt   = w_hit_max;
                    w_state_nxt = (bus.s_last || w_hit_max) ? ST_OUT : ST_ACC;
                end
            end
            ST_OUT: begin
                if (bus.m_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_acc   <= 48'd0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Handshake outputs decode state only, so m_ready never reaches s_ready
    // combinationally. Result fields come straight from the registers and
    // therefore hold still for as long as the block sits in ST_OUT.
    assign bus.s_ready  = (r_state != ST_OUT);
    assign bus.m_valid  = (r_state == ST_OUT);
    assign bus.m_result = r_acc;
    assign bus.m_terms  = r_cnt;
    assign bus.m_ovf    = r_ovf;
    assign bus.m_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bike_mac_stream.sv
//==============================================================================
// Module      : tb_bike_mac_stream
// Description : Self-checking bench for bike_mac_stream. Two instances: one at
//               MAX_TERMS=1024 for the general tests, one at MAX_TERMS=4 for
//               forced termination; a select bit steers the shared stimulus.
//               Expected results are produced by a behavioural model when
//               terms are accepted and compared as the DUT delivers them.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bike_mac_stream;

    localparam int c_MAX_A = 1024;
    localparam int c_MAX_B = 4;

    typedef struct packed {
        logic [47:0] result;
        logic [10:0] terms;
        logic        ovf;
        logic        err;
    } res_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    bike_mac_stream_if #(.MAX_TERMS(c_MAX_A)) bus_a ();
    bike_mac_stream_if #(.MAX_TERMS(c_MAX_B)) bus_b ();

    bike_mac_stream #(.MAX_TERMS(c_MAX_A)) u_dut_a (.clk(clk), .resetn(resetn), .bus(bus_a));
    bike_mac_stream #(.MAX_TERMS(c_MAX_B)) u_dut_b (.clk(clk), .resetn(resetn), .bus(bus_b));

    logic        sel;
    logic        s_valid;
    logic [24:0] s_a;
    logic [17:0] s_b;
    logic [47:0] s_bias;
    logic        s_last;
    logic        m_ready;

    assign bus_a.s_valid = s_valid & ~sel;
    assign bus_b.s_valid = s_valid & sel;
    assign bus_a.m_ready = m_ready & ~sel;
    assign bus_b.m_ready = m_ready & sel;
    assign bus_a.s_a = s_a;     assign bus_b.s_a = s_a;
    assign bus_a.s_b = s_b;     assign bus_b.s_b = s_b;
    assign bus_a.s_bias = s_bias; assign bus_b.s_bias = s_bias;
    assign bus_a.s_last = s_last; assign bus_b.s_last = s_last;

    logic        s_ready_o;
    logic        m_valid_o;
    logic [47:0] m_result_o;
    logic [10:0] m_terms_o;
    logic        m_ovf_o;
    logic        m_err_o;

    assign s_ready_o  = sel ? bus_b.s_ready  : bus_a.s_ready;
    assign m_valid_o  = sel ? bus_b.m_valid  : bus_a.m_valid;
    assign m_result_o = sel ? bus_b.m_result : bus_a.m_result;
    assign m_terms_o  = sel ? {8'd0, bus_b.m_terms} : bus_a.m_terms;
    assign m_ovf_o    = sel ? bus_b.m_ovf    : bus_a.m_ovf;
    assign m_err_o    = sel ? bus_b.m_err    : bus_a.m_err;

    res_t exp_q[$];
    res_t got_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Behavioural model of the burst in progress.
    logic [47:0] md_acc;
    int          md_cnt;
    logic        md_ovf;
    logic        md_err;
    bit          md_first = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Result capture on every output transfer.
    always @(posedge clk) begin
        if (resetn && m_valid_o && m_ready) begin
            res_t r;
            r.result = m_result_o;
            r.terms  = m_terms_o;
            r.ovf    = m_ovf_o;
            r.err    = m_err_o;
            got_q.push_back(r);
        end
    end

    initial begin
        #500000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_accept(input logic [24:0] a, input logic [17:0] b,
                                input logic [47:0] bias, input logic last);
        logic [48:0] sum;
        int          maxt;
        res_t        r;
        maxt = sel ? c_MAX_B : c_MAX_A;
        if (md_first) begin
            md_ovf = 1'b0;
            md_err = 1'b0;
            md_cnt = 0;
            sum = {1'b0, bias} + ({24'd0, a} * {31'd0, b});
        end else begin
            sum = {1'b0, md_acc} + ({24'd0, a} * {31'd0, b});
        end
`ifdef BIKE_MAC_SATURATE_EN
        if (!md_ovf) begin
            if (sum[48]) begin
                md_acc = 48'hFFFF_FFFF_FFFF;
                md_ovf = 1'b1;
            end else begin
                md_acc = sum[47:0];
            end
        end
`else
        md_acc = sum[47:0];
        if (sum[48]) md_ovf = 1'b1;
`endif
        md_cnt++;
        if (!md_first && md_cnt == maxt) md_err = 1'b1;
        md_first = 1'b0;
        if (last || md_err) begin
            r.result = md_acc;
            r.terms  = 11'(md_cnt);
            r.ovf    = md_ovf;
            r.err    = md_err;
            exp_q.push_back(r);
            md_first = 1'b1;
        end
    endtask

    // Presents one term and returns #1 after the edge on which it transferred.
    task automatic send(input logic [24:0] a, input logic [17:0] b,
                        input logic [47:0] bias, input logic last, input bit hold);
        bit   done;
        logic rdy;
        done    = 1'b0;
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        s_bias  = bias;
        s_last  = last;
        for (int i = 0; i < 100; i++) begin
            rdy = s_ready_o;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        if (done) model_accept(a, b, bias, last);
        else      chk("send_timeout", 64'd0, 64'd1);
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic check_next(input string tag, output res_t got);
        res_t expv;
        got = '0;
        for (int i = 0; i < 50; i++) begin
            if (got_q.size() != 0) break;
            @(posedge clk);
            #1;
        end
        if (got_q.size() == 0 || exp_q.size() == 0) begin
            chk({tag, "_no_result"}, 64'(got_q.size()), 64'(exp_q.size() + 1));
        end else begin
            got  = got_q.pop_front();
            expv = exp_q.pop_front();
            chk({tag, "_result"}, 64'(got.result), 64'(expv.result));
            chk({tag, "_terms"},  64'(got.terms),  64'(expv.terms));
            chk({tag, "_ovf"},    64'(got.ovf),    64'(expv.ovf));
            chk({tag, "_err"},    64'(got.err),    64'(expv.err));
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_s_ready"},  64'(s_ready_o),  64'd1);
        chk({tag, "_m_valid"},  64'(m_valid_o),  64'd0);
    endtask

    initial begin
        res_t        got;
        int          t0;
        logic [47:0] ovf_exp;

        sel = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_bias = '0;
        s_last = 1'b0; m_ready = 1'b1; resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values while held in reset.
        check_idle("rst");
        chk("rst_m_result", 64'(m_result_o), 64'd0);
        chk("rst_m_terms",  64'(m_terms_o),  64'd0);
        chk("rst_m_ovf",    64'(m_ovf_o),    64'd0);
        chk("rst_m_err",    64'(m_err_o),    64'd0);
        resetn = 1'b1;

        // Reset in the middle of a burst drops it.
        send(25'd1, 18'd1, 48'd5, 1'b0, 1'b1);
        send(25'd2, 18'd1, 48'd5, 1'b0, 1'b1);
        send(25'd3, 18'd1, 48'd5, 1'b0, 1'b0);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        md_first = 1'b1;
        check_idle("midrst");
        chk("midrst_m_result", 64'(m_result_o), 64'd0);
        send(25'd2, 18'd3, 48'd0, 1'b1, 1'b0);
        check_next("single", got);
        chk("single_const", 64'(got.result), 64'd6);
        chk("single_nores", 64'(got_q.size()), 64'd0);

        // Streamed burst, one term per cycle, result one cycle after.
        @(posedge clk); #1;
        t0 = cyc;
        send(25'd1, 18'd1, 48'd100, 1'b0, 1'b1);
        send(25'd2, 18'd2, 48'd100, 1'b0, 1'b1);
        send(25'd3, 18'd3, 48'd100, 1'b1, 1'b0);
        chk("stream_cycles",   64'(cyc - t0), 64'd3);
        chk("stream_m_valid",  64'(m_valid_o), 64'd1);
        chk("stream_s_ready",  64'(s_ready_o), 64'd0);
        chk("stream_m_result", 64'(m_result_o), 64'd114);
        @(posedge clk); #1;
        check_idle("stream_after");
        check_next("stream", got);
        chk("stream_terms_const", 64'(got.terms), 64'd3);

        // Backpressure: outputs frozen until m_ready.
        m_ready = 1'b0;
        send(25'd1, 18'd1, 48'd100, 1'b0, 1'b1);
        send(25'd2, 18'd2, 48'd100, 1'b0, 1'b1);
        send(25'd3, 18'd3, 48'd100, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_m_valid",  64'(m_valid_o),  64'd1);
            chk("bp_s_ready",  64'(s_ready_o),  64'd0);
            chk("bp_m_result", 64'(m_result_o), 64'd114);
            chk("bp_m_terms",  64'(m_terms_o),  64'd3);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        check_idle("bp_after");
        check_next("bp", got);

        // Bubbles between terms.
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            send(25'd5, 18'd7, 48'd0, (k == 3), 1'b0);
        end
        check_next("bubble", got);
        chk("bubble_const",       64'(got.result), 64'd140);
        chk("bubble_terms_const", 64'(got.terms),  64'd4);

        // Overflow on a single term.
        send(25'h1FF_FFFF, 18'h3FFFF, 48'hFFFF_FFFF_FFF6, 1'b1, 1'b0);
`ifdef BIKE_MAC_SATURATE_EN
        ovf_exp = 48'hFFFF_FFFF_FFFF;
`else
        ovf_exp = 48'd8796059205623;
`endif
        check_next("ovf1", got);
        chk("ovf1_const",     64'(got.result), 64'(ovf_exp));
        chk("ovf1_flag_const", 64'(got.ovf),   64'd1);

        // Overflow mid-burst stays sticky; next burst starts clean.
        send(25'd4, 18'd1, 48'hFFFF_FFFF_FFF6, 1'b0, 1'b1);
        send(25'd4, 18'd1, 48'd0, 1'b0, 1'b1);
        send(25'd4, 18'd1, 48'd0, 1'b0, 1'b1);
        send(25'd1, 18'd1, 48'd0, 1'b1, 1'b0);
        check_next("ovf2", got);
        send(25'd1, 18'd1, 48'd0, 1'b1, 1'b0);
        check_next("ovf_clear", got);
        chk("ovf_clear_const", 64'(got.ovf), 64'd0);

        // Forced termination at MAX_TERMS = 4.
        @(posedge clk); #1;
        sel = 1'b1;
        @(posedge clk); #1;
        check_idle("b_idle");
        for (int k = 0; k < 6; k++) begin
            send(25'd1, 18'd1, 48'd0, (k == 5), (k != 5));
        end
        check_next("force1", got);
        chk("force1_terms_const",  64'(got.terms),  64'd4);
        chk("force1_err_const",    64'(got.err),    64'd1);
        chk("force1_result_const", 64'(got.result), 64'd4);
        check_next("force2", got);
        chk("force2_terms_const",  64'(got.terms),  64'd2);
        chk("force2_err_const",    64'(got.err),    64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
